instruction_decode: RTL and testbench
=====================================

# instruction_decode

Second pipeline stage of the RISC-V core. Registers the fetch stage's instruction word (IFID) and its PC into the ID/EX pipeline register, reads a 32 x 32-bit register file, and generates the sign-extended immediate. Resolves conditional branches sitting in ID/EX and drives PCSelect/PCBranch back to instruction_fetch, closing the fetch/decode loop. Writeback enters through a dedicated register-file write port.

## Interface
Parameters: none. NOP = 32'h00000000; opcodes R_Type 0110011, I_Type 0010011, Lw 0000011, Sw 0100011, B_Type 1100011, J_Type 1101111.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- IFID  in  32  instruction from fetch (NOP during stalls/bubbles)
- IFID_PC  in  8  byte PC of IFID
- wb_en  in  1  register-file write enable
- wb_rd  in  5  write address
- wb_data  in  32  write data
- IDEX  out  40  registered {PC[7:0], instruction[31:0]}; [6:0] opcode, [11:7] rd
- IDEX_A  out  32  registered rs1 value
- IDEX_B  out  32  registered rs2 value
- IDEX_imm  out  32  registered immediate
- PCSelect  out  1  branch taken; redirect fetch
- PCBranch  out  8  branch target byte address

## Operation
- Register file: 32 x 32; x0 reads 0 always; writes to x0 are ignored. Write on posedge clk when wb_en.
- Read bypass: if wb_en and wb_rd == rs (nonzero) in the same cycle, the read returns wb_data, not the stale entry.
- rs1 = IFID[19:15], rs2 = IFID[24:20]; read for every opcode (don't-care fields are harmless).
- Immediate by IFID opcode, sign-extended to 32:
  - I_Type/Lw: ins[31:20]
  - Sw: {ins[31:25], ins[11:7]}
  - B_Type: {ins[31], ins[7], ins[30:25], ins[11:8], 0}
  - J_Type: {ins[31], ins[19:12], ins[20], ins[30:21], 0}
  - all others: 0
- Each posedge clk: IDEX <= {IFID_PC, IFID}; IDEX_A/IDEX_B <= bypassed reads; IDEX_imm <= immediate. No stall input; bubbles arrive as NOP from fetch.
- Branch resolution (combinational from ID/EX registers): when IDEX[6:0] == B_Type, compare IDEX_A vs IDEX_B by funct3 = IDEX[14:12]:
  - 000 BEQ, 001 BNE, 100 BLT signed, 101 BGE signed, 110 BLTU, 111 BGEU
  - 010/011: not taken
- Taken: PCSelect = 1, PCBranch = (IDEX[39:32] + IDEX_imm[7:0]) mod 256. Otherwise PCSelect = 0, PCBranch = 0.
- J_Type is decoded (immediate only). This block does not redirect it.

## Timing
- Reset (async, immediate): IDEX = 0, IDEX_A = IDEX_B = IDEX_imm = 0, all 32 registers = 0; hence PCSelect = 0, PCBranch = 0.
- Latency: IFID presented in cycle N appears on IDEX/operands after edge N+1. PCSelect for a branch is valid throughout cycle N+1, for exactly one cycle. Fetch holds NOPs behind a branch, so the next IDEX is NOP and PCSelect drops.
- Write-then-read: wb write at edge E is visible to a read in cycle E. The same-cycle bypass makes it visible before E as well.
- Simultaneous wb_en to rd = rs1 = rs2: both operands take wb_data.
- Reset asserted mid-branch: PCSelect drops combinationally as IDEX clears. Release resumes with an all-zero register file.
- PCBranch wraps modulo 256; negative offsets subtract.

## Test plan
- Reset: assert rst with IFID = random nonzero -> all outputs 0, PCSelect = 0. Release, hold NOP -> outputs stay 0.
- Register file: write x5 = 32'hDEADBEEF, then IFID = add x1,x5,x5 -> next cycle IDEX_A = IDEX_B = DEADBEEF. Write x0 = 1, read x0 -> 0.
- Bypass: same cycle wb_en, wb_rd = 7, wb_data = 32'h12345678, IFID with rs1 = 7 -> IDEX_A = 12345678 after the edge.
- Immediates:
  - addi imm -1 -> IDEX_imm = FFFFFFFF
  - sw offset 8 -> 00000008
  - beq offset -4 -> FFFFFFFC
- BEQ taken: x1 = x2 = 3, IFID = beq x1,x2,+12 at IFID_PC = 8'h10 -> next cycle PCSelect = 1, PCBranch = 8'h1C, one cycle only. BNE on the same operands -> PCSelect = 0.
- Signed vs unsigned: x1 = FFFFFFFF, x2 = 1. BLT -> taken. BLTU -> not taken. BGEU -> taken. Also cover wrap: IFID_PC = 8'h04, offset -8 -> PCBranch = 8'hFC.

Source files
------------

// File: rtl/instruction_decode_if.sv
//==============================================================================
// Module      : instruction_decode_if
// Description : Fetch/writeback-to-decode bundle and the ID/EX pipeline outputs.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface instruction_decode_if;
  logic [31:0] IFID;
  logic [7:0]  IFID_PC;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [39:0] IDEX;
  logic [31:0] IDEX_A;
  logic [31:0] IDEX_B;
  logic [31:0] IDEX_imm;
  logic        PCSelect;
  logic [7:0]  PCBranch;

  // Master drives the decode stage (fetch + writeback side).
  modport master (
    output IFID, IFID_PC, wb_en, wb_rd, wb_data,
    input  IDEX, IDEX_A, IDEX_B, IDEX_imm, PCSelect, PCBranch
  );

  modport slave (
    input  IFID, IFID_PC, wb_en, wb_rd, wb_data,
    output IDEX, IDEX_A, IDEX_B, IDEX_imm, PCSelect, PCBranch
  );
endinterface

`default_nettype wire

// File: rtl/instruction_decode.sv
//==============================================================================
// Module      : instruction_decode
// Description : RISC-V decode stage: register file, immediate gen, ID/EX
//               register and branch resolution driving fetch redirect.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module instruction_decode (
  input  wire logic            clk,
  input  wire logic            rst,
  instruction_decode_if.slave  dec_if
);

  localparam logic [6:0] c_OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] c_OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] c_OP_LW     = 7'b0000011;
  localparam logic [6:0] c_OP_SW     = 7'b0100011;
  localparam logic [6:0] c_OP_B_TYPE = 7'b1100011;
  localparam logic [6:0] c_OP_J_TYPE = 7'b1101111;

  logic [31:0] rf_q [32];
  logic [39:0] idex_q;
  logic [31:0] idex_a_q;
  logic [31:0] idex_b_q;
  logic [31:0] idex_imm_q;

  logic [31:0] w_ins;
  logic [6:0]  w_opcode;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [31:0] w_rs1_val;
  logic [31:0] w_rs2_val;
  logic [31:0] w_imm;
  logic        w_taken;
  logic [2:0]  w_funct3;

  assign w_ins    = dec_if.IFID;
  assign w_opcode = w_ins[6:0];
  assign w_rs1    = w_ins[19:15];
  assign w_rs2    = w_ins[24:20];

  // Same-cycle writeback wins over the stored entry so the reader never sees stale data.
  always_comb begin
    w_rs1_val = rf_q[w_rs1];
    w_rs2_val = rf_q[w_rs2];
    if (dec_if.wb_en && (dec_if.wb_rd == w_rs1)) w_rs1_val = dec_if.wb_data;
    if (dec_if.wb_en && (dec_if.wb_rd == w_rs2)) w_rs2_val = dec_if.wb_data;
    if (w_rs1 == 5'd0) w_rs1_val = 32'd0;
    if (w_rs2 == 5'd0) w_rs2_val = 32'd0;
  end

  always_comb begin
    w_imm = 32'd0;
    case (w_opcode)
      c_OP_I_TYPE, c_OP_LW:
        w_imm = {{20{w_ins[31]}}, w_ins[31:20]};
      c_OP_SW:
        w_imm = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
      c_OP_B_TYPE:
        w_imm = {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
      c_OP_J_TYPE:
        w_imm = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};
      c_OP_R_TYPE:
        w_imm = 32'd0;
      default:
        w_imm = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= 32'd0;
      end
      idex_q     <= 40'd0;
      idex_a_q   <= 32'd0;
      idex_b_q   <= 32'd0;
      idex_imm_q <= 32'd0;
    end else begin
      if (dec_if.wb_en && (dec_if.wb_rd != 5'd0)) begin
        rf_q[dec_if.wb_rd] <= dec_if.wb_data;
      end
      idex_q     <= {dec_if.IFID_PC, dec_if.IFID};
      idex_a_q   <= w_rs1_val;
      idex_b_q   <= w_rs2_val;
      idex_imm_q <= w_imm;
    end
  end

  assign w_funct3 = idex_q[14:12];

  always_comb begin
    w_taken = 1'b0;
    if (idex_q[6:0] == c_OP_B_TYPE) begin
      case (w_funct3)
        3'b000:  w_taken = (idex_a_q == idex_b_q);
        3'b001:  w_taken = (idex_a_q != idex_b_q);
        3'b100:  w_taken = ($signed(idex_a_q) <  $signed(idex_b_q));
        3'b101:  w_taken = ($signed(idex_a_q) >= $signed(idex_b_q));
        3'b110:  w_taken = (idex_a_q <  idex_b_q);
        3'b111:  w_taken = (idex_a_q >= idex_b_q);
        default: w_taken = 1'b0;
      endcase
    end
  end

  assign dec_if.IDEX     = idex_q;
  assign dec_if.IDEX_A   = idex_a_q;
  assign dec_if.IDEX_B   = idex_b_q;
  assign dec_if.IDEX_imm = idex_imm_q;
  assign dec_if.PCSelect = w_taken;
  assign dec_if.PCBranch = w_taken ? (idex_q[39:32] + idex_imm_q[7:0]) : 8'd0;

endmodule

`default_nettype wire

// File: tb/tb_instruction_decode.sv
//==============================================================================
// Module      : tb_instruction_decode
// Description : Directed self-checking bench for the decode stage.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_instruction_decode;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  instruction_decode_if dif ();

  instruction_decode u_dut (
    .clk    (clk),
    .rst    (rst),
    .dec_if (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_s(input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic wb_write(input logic [4:0] rd, input logic [31:0] data);
    dif.wb_en   = 1'b1;
    dif.wb_rd   = rd;
    dif.wb_data = data;
    dif.IFID    = 32'd0;
    step();
    dif.wb_en   = 1'b0;
  endtask

  task automatic branch_chk(input string tag, input logic [31:0] ins, input logic [7:0] pc,
                            input logic exp_sel, input logic [7:0] exp_tgt);
    dif.IFID    = ins;
    dif.IFID_PC = pc;
    step();
    check_eq({tag, "_sel"}, {39'd0, dif.PCSelect}, {39'd0, exp_sel});
    check_eq({tag, "_tgt"}, {32'd0, dif.PCBranch}, {32'd0, exp_tgt});
  endtask

  logic [31:0] ins;

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    dif.IFID    = 32'hA5A5_1263;
    dif.IFID_PC = 8'h55;
    dif.wb_en   = 1'b1;
    dif.wb_rd   = 5'd3;
    dif.wb_data = 32'h1111_2222;
    step();
    step();
    check_eq("rst_idex", dif.IDEX, 40'd0);
    check_eq("rst_a", {8'd0, dif.IDEX_A}, 40'd0);
    check_eq("rst_b", {8'd0, dif.IDEX_B}, 40'd0);
    check_eq("rst_imm", {8'd0, dif.IDEX_imm}, 40'd0);
    check_eq("rst_sel", {39'd0, dif.PCSelect}, 40'd0);
    check_eq("rst_tgt", {32'd0, dif.PCBranch}, 40'd0);

    rst         = 1'b0;
    dif.IFID    = 32'd0;
    dif.IFID_PC = 8'd0;
    dif.wb_en   = 1'b0;
    step();
    step();
    check_eq("nop_idex", dif.IDEX, 40'd0);
    check_eq("nop_sel", {39'd0, dif.PCSelect}, 40'd0);

    // Register file write then read through the pipeline register.
    wb_write(5'd5, 32'hDEAD_BEEF);
    ins         = enc_r(5'd1, 5'd5, 5'd5);
    dif.IFID    = ins;
    dif.IFID_PC = 8'h24;
    step();
    check_eq("rf_a", {8'd0, dif.IDEX_A}, {8'd0, 32'hDEAD_BEEF});
    check_eq("rf_b", {8'd0, dif.IDEX_B}, {8'd0, 32'hDEAD_BEEF});
    check_eq("idex_word", dif.IDEX, {8'h24, 32'h0052_80B3});
    check_eq("r_imm", {8'd0, dif.IDEX_imm}, 40'd0);

    // x0 stays zero, both with same-cycle write and afterwards.
    dif.wb_en   = 1'b1;
    dif.wb_rd   = 5'd0;
    dif.wb_data = 32'd1;
    dif.IFID    = enc_r(5'd1, 5'd0, 5'd0);
    step();
    check_eq("x0_byp", {8'd0, dif.IDEX_A}, 40'd0);
    dif.wb_en   = 1'b0;
    step();
    check_eq("x0_rd", {8'd0, dif.IDEX_A}, 40'd0);

    // Same-cycle bypass.
    dif.wb_en   = 1'b1;
    dif.wb_rd   = 5'd7;
    dif.wb_data = 32'h1234_5678;
    dif.IFID    = enc_r(5'd2, 5'd7, 5'd0);
    step();
    check_eq("byp_a", {8'd0, dif.IDEX_A}, {8'd0, 32'h1234_5678});
    check_eq("byp_b", {8'd0, dif.IDEX_B}, 40'd0);

    // Both operands bypass from a single write.
    dif.wb_rd   = 5'd9;
    dif.wb_data = 32'hCAFE_F00D;
    dif.IFID    = enc_r(5'd3, 5'd9, 5'd9);
    step();
    dif.wb_en   = 1'b0;
    check_eq("byp2_a", {8'd0, dif.IDEX_A}, {8'd0, 32'hCAFE_F00D});
    check_eq("byp2_b", {8'd0, dif.IDEX_B}, {8'd0, 32'hCAFE_F00D});

    // Immediates.
    dif.IFID = enc_i(5'd1, 5'd0, 12'hFFF);
    step();
    check_eq("imm_addi", {8'd0, dif.IDEX_imm}, {8'd0, 32'hFFFF_FFFF});
    dif.IFID = enc_s(5'd0, 5'd5, 12'h008);
    step();
    check_eq("imm_sw", {8'd0, dif.IDEX_imm}, {8'd0, 32'h0000_0008});
    dif.IFID = enc_j(5'd1, 21'h12344);
    step();
    check_eq("imm_jal", {8'd0, dif.IDEX_imm}, {8'd0, 32'h0001_2344});
    check_eq("jal_sel", {39'd0, dif.PCSelect}, 40'd0);
    branch_chk("beq_m4", enc_b(3'b000, 5'd0, 5'd0, 13'h1FFC), 8'h20, 1'b1, 8'h1C);
    check_eq("imm_beq", {8'd0, dif.IDEX_imm}, {8'd0, 32'hFFFF_FFFC});
    branch_chk("beq_big", enc_b(3'b000, 5'd0, 5'd0, 13'h0FFE), 8'h10, 1'b1, 8'h0E);
    check_eq("imm_big", {8'd0, dif.IDEX_imm}, {8'd0, 32'h0000_0FFE});

    // BEQ taken for exactly one cycle, then BNE / reserved funct3.
    wb_write(5'd1, 32'd3);
    wb_write(5'd2, 32'd3);
    branch_chk("beq_t", enc_b(3'b000, 5'd1, 5'd2, 13'h00C), 8'h10, 1'b1, 8'h1C);
    branch_chk("beq_bub", 32'd0, 8'h14, 1'b0, 8'h00);
    branch_chk("bne_nt", enc_b(3'b001, 5'd1, 5'd2, 13'h00C), 8'h10, 1'b0, 8'h00);
    branch_chk("f3_010", enc_b(3'b010, 5'd1, 5'd2, 13'h00C), 8'h10, 1'b0, 8'h00);

    // Signed vs unsigned compares: x1 = -1, x2 = 1.
    wb_write(5'd1, 32'hFFFF_FFFF);
    wb_write(5'd2, 32'd1);
    branch_chk("blt", enc_b(3'b100, 5'd1, 5'd2, 13'h010), 8'h40, 1'b1, 8'h50);
    branch_chk("bge", enc_b(3'b101, 5'd1, 5'd2, 13'h010), 8'h40, 1'b0, 8'h00);
    branch_chk("bltu", enc_b(3'b110, 5'd1, 5'd2, 13'h010), 8'h40, 1'b0, 8'h00);
    branch_chk("bgeu", enc_b(3'b111, 5'd1, 5'd2, 13'h010), 8'h40, 1'b1, 8'h50);
    branch_chk("bne_t", enc_b(3'b001, 5'd1, 5'd2, 13'h010), 8'h40, 1'b1, 8'h50);
    branch_chk("wrap", enc_b(3'b000, 5'd0, 5'd0, 13'h1FF8), 8'h04, 1'b1, 8'hFC);

    // Async reset during a taken branch, then the register file reads back cleared.
    branch_chk("pre_rst", enc_b(3'b110, 5'd2, 5'd1, 13'h008), 8'h30, 1'b1, 8'h38);
    rst = 1'b1;
    #1;
    check_eq("arst_sel", {39'd0, dif.PCSelect}, 40'd0);
    check_eq("arst_idex", dif.IDEX, 40'd0);
    rst         = 1'b0;
    dif.IFID    = enc_r(5'd3, 5'd1, 5'd5);
    dif.IFID_PC = 8'h00;
    step();
    check_eq("clr_a", {8'd0, dif.IDEX_A}, 40'd0);
    check_eq("clr_b", {8'd0, dif.IDEX_B}, 40'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
